// File: rtl/memory.sv
// ============================================================================
// Module   : memory
// Summary  : Single-port register-file memory with an IDLE/ACCESS/DONE
//            sequencer and a registered one-cycle ready pulse per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] din_q,   din_d;
  logic                  op_q,    op_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    op_d    = op_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    mem_d   = mem_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving a 2-cycle cadence
      ST_IDLE, ST_DONE: begin
        if (write || read) begin
          addr_d  = addr;
          din_d   = din;
          op_d    = write ? OP_WR : OP_RD;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (op_q == OP_WR) begin
          mem_d[addr_q] = din_q;
        end else begin
          dout_d = mem_q[addr_q];
        end
        ready_d = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      op_q    <= OP_RD;
      dout_q  <= '0;
      ready_q <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      mem_q   <= mem_d;
    end
  end

  assign dout  = dout_q;
  assign ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
// Module   : tb_memory
// Summary  : Self-checking bench for memory: directed scenarios plus random
//            transactions compared against a transaction-level array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          ready;

  int errors;
  int checks;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_dout;

  memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .read  (read),
    .write (write),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_dout = '0;
  endtask

  // Transaction-level effect of one accepted request
  task automatic model_apply(input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    if (wr) model_mem[a] = d;
    else if (rd) model_dout = model_mem[a];
  endtask

  // Called at a negedge where the DUT can accept (IDLE or DONE). Returns at
  // the negedge of the DONE cycle, after 'gap' further idle cycles.
  task automatic issue(input string tag, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    read  = rd;
    write = wr;
    addr  = a;
    din   = d;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    addr  = AW'($urandom);
    din   = DW'($urandom);
    check({tag, "_busy_ready"}, 32'(ready), 32'd0);
    model_apply(rd, wr, a, d);
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(model_dout));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check({tag, "_idle_ready"}, 32'(ready), 32'd0);
      check({tag, "_idle_dout"}, 32'(dout), 32'(model_dout));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    read   = 1'b0;
    write  = 1'b0;
    addr   = '0;
    din    = '0;
    model_reset();

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset = 1'b1;
    issue("rst_rd7", 1'b1, 1'b0, 4'd7, 8'h00, 1);

    // Directed writes then reads
    issue("wr0", 1'b0, 1'b1, 4'd0, 8'hA5, 1);
    issue("wr1", 1'b0, 1'b1, 4'd1, 8'h5A, 1);
    issue("wr2", 1'b0, 1'b1, 4'd2, 8'hFF, 1);
    issue("wr3", 1'b0, 1'b1, 4'd3, 8'h12, 1);
    issue("wr4", 1'b0, 1'b1, 4'd4, 8'h00, 1);
    issue("rd0", 1'b1, 1'b0, 4'd0, 8'h00, 1);
    check("rd0_val", 32'(dout), 32'hA5);
    issue("rd1", 1'b1, 1'b0, 4'd1, 8'h00, 1);
    check("rd1_val", 32'(dout), 32'h5A);
    issue("rd2", 1'b1, 1'b0, 4'd2, 8'h00, 1);
    check("rd2_val", 32'(dout), 32'hFF);
    issue("rd3", 1'b1, 1'b0, 4'd3, 8'h00, 1);
    check("rd3_val", 32'(dout), 32'h12);
    issue("rd4", 1'b1, 1'b0, 4'd4, 8'h00, 1);
    check("rd4_val", 32'(dout), 32'h00);

    // Back-to-back: read accepted in the DONE cycle of the write
    issue("b2b_wr5", 1'b0, 1'b1, 4'd5, 8'h3C, 0);
    issue("b2b_rd5", 1'b1, 1'b0, 4'd5, 8'h00, 1);
    check("b2b_val", 32'(dout), 32'h3C);

    // Simultaneous strobes: write wins, dout untouched
    issue("pre_rd3", 1'b1, 1'b0, 4'd3, 8'h00, 1);
    issue("both6", 1'b1, 1'b1, 4'd6, 8'h77, 1);
    check("both6_dout", 32'(dout), 32'h12);
    issue("rd6", 1'b1, 1'b0, 4'd6, 8'h00, 1);
    check("rd6_val", 32'(dout), 32'h77);

    // Strobe during ACCESS is ignored
    write = 1'b1;
    addr  = 4'd8;
    din   = 8'h11;
    @(negedge clk);
    addr  = 4'd8;
    din   = 8'h22;
    model_apply(1'b0, 1'b1, 4'd8, 8'h11);
    check("busy_ready0", 32'(ready), 32'd0);
    @(negedge clk);
    write = 1'b0;
    check("busy_ready1", 32'(ready), 32'd1);
    @(negedge clk);
    check("busy_single_pulse", 32'(ready), 32'd0);
    @(negedge clk);
    check("busy_no_retrigger", 32'(ready), 32'd0);
    issue("rd8", 1'b1, 1'b0, 4'd8, 8'h00, 1);
    check("rd8_val", 32'(dout), 32'h11);

    // Reset during ACCESS aborts the write and clears memory
    write = 1'b1;
    addr  = 4'd9;
    din   = 8'hAA;
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(ready), 32'd0);
    check("rstmid_dout", 32'(dout), 32'd0);
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_after_ready", 32'(ready), 32'd0);
    issue("rd9", 1'b1, 1'b0, 4'd9, 8'h00, 1);
    check("rd9_val", 32'(dout), 32'h00);
    issue("rd6_cleared", 1'b1, 1'b0, 4'd6, 8'h00, 0);

    // Randomized traffic with a mix of back-to-back and idle gaps
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      issue("rand", (kind < 5) || (kind == 9), (kind >= 5),
            AW'($urandom), DW'($urandom), int'($urandom_range(0, 2)));
    end
    // Final sweep compares every word with the model
    for (int i = 0; i < DEPTH; i++) begin
      issue("sweep", 1'b1, 1'b0, AW'(i), 8'h00, 0);
      check("sweep_val", 32'(dout), 32'(model_mem[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
